// File: rtl/ddr_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_capture_pkg
// Description : Capture-word layout and MCB command constants shared by the
//               LPDDR capture writer and sample reader.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_capture_pkg;

    localparam int WORD_W           = 32;
    localparam int OR_BIT           = 31;
    localparam int TRIG_BIT         = 30;
    localparam int SAMPLE_W         = 10;
    localparam int SAMPLES_PER_WORD = 3;

    localparam logic [2:0] MCB_CMD_READ  = 3'b001;
    localparam logic [2:0] MCB_CMD_WRITE = 3'b000;

    localparam int BURST_WORDS_DEFAULT = 64;

    typedef logic [1:0] slot_t;

    typedef struct packed {
        logic                ovr;
        logic                trig;
        logic [SAMPLE_W-1:0] data;
    } capture_sample_t;

    // Flags are word-wide, so every slot of a word carries the same ovr/trig.
    function automatic capture_sample_t unpack_sample(input logic [WORD_W-1:0] word,
                                                      input slot_t             slot);
        capture_sample_t s;
        s.ovr  = word[OR_BIT];
        s.trig = word[TRIG_BIT];
        case (slot)
            2'd0:    s.data = word[SAMPLE_W-1:0];
            2'd1:    s.data = word[2*SAMPLE_W-1:SAMPLE_W];
            2'd2:    s.data = word[3*SAMPLE_W-1:2*SAMPLE_W];
            default: s.data = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : capture_word_unpacker
// Description : Holds one capture word and streams its three samples with
//               valid/ready; requests the next word as the last slot leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_word_unpacker
    import ddr_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   i_rd_data,
    input  logic                i_rd_empty,
    input  logic                i_pop_allowed,
    input  logic                i_discard,
    input  logic                i_ready,
    output logic                o_rd_en,
    output logic                o_valid,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_or,
    output logic                o_trig,
    output logic                o_empty
);

    localparam slot_t c_LAST_SLOT = slot_t'(SAMPLES_PER_WORD - 1);

    logic [WORD_W-1:0] r_word;
    slot_t             r_slot;
    logic              r_valid;

    logic              w_accept;
    logic              w_last_accept;
    logic              w_pop;
    capture_sample_t   w_sample;

    assign w_accept      = r_valid & i_ready & ~i_discard;
    assign w_last_accept = w_accept & (r_slot == c_LAST_SLOT);
    // Refill on the same edge the last slot is taken, so words flow without a bubble.
    assign w_pop         = ~i_rd_empty & i_pop_allowed & (~r_valid | w_last_accept | i_discard);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_slot  <= '0;
            r_valid <= 1'b0;
        end else if (i_discard) begin
            r_word  <= '0;
            r_slot  <= '0;
            r_valid <= 1'b0;
        end else if (w_pop) begin
            r_word  <= i_rd_data;
            r_slot  <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            if (w_last_accept) begin
                r_slot  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_slot <= r_slot + slot_t'(1);
            end
        end
    end

    assign w_sample = unpack_sample(r_word, r_slot);

    assign o_rd_en  = w_pop;
    assign o_valid  = r_valid & ~i_discard;
    assign o_data   = w_sample.data;
    assign o_or     = w_sample.ovr;
    assign o_trig   = w_sample.trig;
    assign o_empty  = ~r_valid;

endmodule
`default_nettype wire

// File: rtl/ddr_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : ddr_sample_reader
// Description : Reads ADC capture words back from LPDDR over MCB port p2 in
//               single outstanding bursts and streams the unpacked samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_sample_reader
    import ddr_capture_pkg::*;
#(
    parameter int BURST_WORDS = BURST_WORDS_DEFAULT,
    parameter int ADDR_W      = 30,
    parameter int CNT_W       = 24
) (
    input  logic                ddr_usrclk,
    input  logic                ddr_usrreset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [CNT_W-1:0]    num_words,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cmd_en,
    output logic [2:0]          cmd_instr,
    output logic [5:0]          cmd_bl,
    output logic [ADDR_W-1:0]   cmd_byte_addr,
    input  logic                cmd_full,
    output logic                rd_en,
    input  logic [WORD_W-1:0]   rd_data,
    input  logic                rd_empty,
    input  logic                rd_overflow,
    input  logic                rd_error,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_or,
    output logic                sample_trig,
    output logic                sample_valid,
    input  logic                sample_ready
);

    localparam int c_BL_W = $clog2(BURST_WORDS + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CMD   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    localparam logic [c_BL_W-1:0] c_BURST_MAX = c_BL_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0]  c_BURST_CNT = CNT_W'(BURST_WORDS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [c_BL_W-1:0] r_burst_left;
    logic              r_abort_pending;
    logic              r_err;
    logic              r_done;

    logic [c_BL_W-1:0] w_burst_len;
    logic [ADDR_W-1:0] w_addr_step;
    logic              w_start_go;
    logic              w_abort_now;
    logic              w_discard;
    logic              w_pop_allowed;
    logic              w_unpack_empty;
    logic              w_done_set;

    assign w_burst_len   = (r_remaining >= c_BURST_CNT) ? c_BURST_MAX
                                                        : r_remaining[c_BL_W-1:0];
    assign w_addr_step   = ADDR_W'(w_burst_len) << 2;
    assign w_start_go    = (r_state == c_ST_IDLE) & start & (num_words != '0);
    assign w_abort_now   = abort | r_abort_pending;
    // An abort in flight empties the unpacker and turns remaining pops into discards.
    assign w_discard     = (r_state != c_ST_IDLE) & w_abort_now;
    assign w_pop_allowed = (r_burst_left != '0);

    // ---------------- state register ----------------
    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_go) begin
                    w_state_next = c_ST_CMD;
                end
            end
            c_ST_CMD: begin
                if (w_abort_now) begin
                    w_state_next = c_ST_FLUSH;
                end else if (!cmd_full) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_burst_left == '0) begin
                    w_state_next = ((r_remaining != '0) && !w_abort_now) ? c_ST_CMD
                                                                         : c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                if (w_unpack_empty) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_en        = 1'b0;
        cmd_bl        = '0;
        cmd_byte_addr = '0;
        busy          = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_done_set = start & (num_words == '0);
            end
            c_ST_CMD: begin
                busy          = 1'b1;
                cmd_bl        = 6'(w_burst_len - c_BL_W'(1));
                cmd_byte_addr = r_addr;
                cmd_en        = ~cmd_full & ~w_abort_now;
            end
            c_ST_DRAIN: begin
                busy = 1'b1;
            end
            c_ST_FLUSH: begin
                busy       = 1'b1;
                w_done_set = w_unpack_empty;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_burst_left    <= '0;
            r_abort_pending <= 1'b0;
            r_err           <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= w_done_set;

            if (w_start_go) begin
                r_addr      <= {start_addr[ADDR_W-1:2], 2'b00};
                r_remaining <= num_words;
            end else if (cmd_en) begin
                r_addr      <= r_addr + w_addr_step;
                r_remaining <= r_remaining - CNT_W'(w_burst_len);
            end

            if (cmd_en) begin
                r_burst_left <= w_burst_len;
            end else if (rd_en) begin
                r_burst_left <= r_burst_left - c_BL_W'(1);
            end

            // Aborts while idle are ignored, including one coincident with start.
            if (r_state == c_ST_IDLE) begin
                r_abort_pending <= 1'b0;
            end else if (abort) begin
                r_abort_pending <= 1'b1;
            end

            if ((r_state == c_ST_IDLE) && start) begin
                r_err <= 1'b0;
            end else if (rd_overflow | rd_error) begin
                r_err <= 1'b1;
            end
        end
    end

    capture_word_unpacker u_unpacker (
        .clk           (ddr_usrclk),
        .rst           (ddr_usrreset),
        .i_rd_data     (rd_data),
        .i_rd_empty    (rd_empty),
        .i_pop_allowed (w_pop_allowed),
        .i_discard     (w_discard),
        .i_ready       (sample_ready),
        .o_rd_en       (rd_en),
        .o_valid       (sample_valid),
        .o_data        (sample_data),
        .o_or          (sample_or),
        .o_trig        (sample_trig),
        .o_empty       (w_unpack_empty)
    );

    assign cmd_instr = MCB_CMD_READ;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_sample_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_sample_reader
// Description : Self-checking bench: MCB p2 memory model, randomized traffic
//               and a queue-based reference of commands and sample stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_sample_reader;
    import ddr_capture_pkg::*;

    localparam int ADDR_W = 30;
    localparam int CNT_W  = 24;

    logic              ddr_usrclk   = 1'b0;
    logic              ddr_usrreset = 1'b1;
    logic              start        = 1'b0;
    logic              abort        = 1'b0;
    logic [ADDR_W-1:0] start_addr   = '0;
    logic [CNT_W-1:0]  num_words    = '0;
    logic              busy, done, err, cmd_en, rd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic              cmd_full     = 1'b0;
    logic [31:0]       rd_data      = '0;
    logic              rd_empty     = 1'b1;
    logic              rd_overflow  = 1'b0;
    logic              rd_error     = 1'b0;
    logic [9:0]        sample_data;
    logic              sample_or, sample_trig, sample_valid;
    logic              sample_ready = 1'b1;

    always #5 ddr_usrclk = ~ddr_usrclk;

    ddr_sample_reader dut (
        .ddr_usrclk    (ddr_usrclk),
        .ddr_usrreset  (ddr_usrreset),
        .start         (start),
        .abort         (abort),
        .start_addr    (start_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_full      (cmd_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .rd_overflow   (rd_overflow),
        .rd_error      (rd_error),
        .sample_data   (sample_data),
        .sample_or     (sample_or),
        .sample_trig   (sample_trig),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents and run settings ----------------
    int          g_mode     = 0;
    logic [29:0] g_base     = '0;
    int          g_rdy_mode = 0;
    int          g_stall    = 0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [29:0] k;
        logic [31:0] t;
        logic [9:0]  s0;
        case (g_mode)
            0: begin
                k  = (a - g_base) >> 2;
                t  = 32'(k) * 32'd3;
                s0 = t[9:0];
                return {k[1], k[0], s0 + 10'd2, s0 + 10'd1, s0};
            end
            1:       return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
            default: return 32'hC00F_FC00;
        endcase
    endfunction

    // ---------------- reference expectations ----------------
    logic [35:0] exp_cmd[$];
    logic [11:0] exp_samp[$];
    logic [31:0] rdq[$];
    int          n_cmd_exp, n_samp_exp;

    task automatic build_expect(input int nw);
        logic [29:0] a;
        logic [31:0] w;
        int          rem, b;
        exp_cmd.delete();
        exp_samp.delete();
        n_cmd_exp  = 0;
        n_samp_exp = 3 * nw;
        rem = nw;
        a   = g_base;
        while (rem > 0) begin
            b = (rem > 64) ? 64 : rem;
            exp_cmd.push_back({6'(b - 1), a});
            a = a + 30'(4 * b);
            rem -= b;
            n_cmd_exp++;
        end
        for (int i = 0; i < nw; i++) begin
            w = mem_word(g_base + 30'(4 * i));
            exp_samp.push_back({w[31], w[30], w[9:0]});
            exp_samp.push_back({w[31], w[30], w[19:10]});
            exp_samp.push_back({w[31], w[30], w[29:20]});
        end
    endtask

    // ---------------- monitor (negedge) ----------------
    int          cyc = 0;
    int          start_cyc, first_cmd_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
    int          n_cmd, n_pop, n_acc, n_done;
    bit          aborted   = 0;
    bit          prev_hold = 0;
    logic [11:0] prev_samp, m_s;
    logic [35:0] m_e;
    logic [31:0] m_w;

    always @(negedge ddr_usrclk) begin
        cyc++;
        if (ddr_usrreset) begin
            prev_hold = 0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (cmd_en) begin
                if (n_cmd == 0) first_cmd_cyc = cyc;
                n_cmd++;
                check_eq("cmd_full_at_en", cmd_full, 0);
                check_eq("cmd_instr", cmd_instr, 3'b001);
                if (exp_cmd.size() > 0) begin
                    m_e = exp_cmd.pop_front();
                    check_eq("cmd_bl", cmd_bl, m_e[35:30]);
                    check_eq("cmd_addr", cmd_byte_addr, m_e[29:0]);
                end else begin
                    check_eq("cmd_extra", n_cmd, n_cmd_exp);
                end
                for (int j = 0; j <= int'(cmd_bl); j++)
                    rdq.push_back(mem_word(cmd_byte_addr + 30'(4 * j)));
            end
            if (rd_en) begin
                n_pop++;
                check_eq("rd_en_on_empty", rd_empty, 0);
                if (rdq.size() > 0) m_w = rdq.pop_front();
            end
            if (abort) aborted = 1;
            if (prev_hold && !aborted) begin
                check_eq("hold_valid", sample_valid, 1);
                check_eq("hold_sample", {sample_or, sample_trig, sample_data}, prev_samp);
            end
            if (aborted && sample_valid) check_eq("valid_after_abort", sample_valid, 0);
            if (sample_valid && sample_ready && !aborted) begin
                if (n_acc == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                n_acc++;
                if (exp_samp.size() > 0) begin
                    m_s = exp_samp.pop_front();
                    check_eq("sample", {sample_or, sample_trig, sample_data}, m_s);
                end else begin
                    check_eq("sample_extra", n_acc, n_samp_exp);
                end
            end
            prev_hold = sample_valid && !sample_ready;
            prev_samp = {sample_or, sample_trig, sample_data};
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- MCB read FIFO + consumer driver ----------------
    initial begin
        forever begin
            @(posedge ddr_usrclk);
            #1;
            case (g_rdy_mode)
                0:       sample_ready = 1'b1;
                1:       sample_ready = ($urandom_range(0, 2) != 0);
                default: sample_ready = ~sample_ready;
            endcase
            if (rdq.size() > 0) rd_data = rdq[0];
            rd_empty = (rdq.size() == 0) || (g_stall != 0 && $urandom_range(0, 3) == 0);
        end
    end

    task automatic clear_run_stats();
        n_cmd = 0; n_pop = 0; n_acc = 0; n_done = 0;
        aborted = 0; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        first_cmd_cyc = -1; start_cyc = -1;
    endtask

    task automatic run(input logic [29:0] addr, input int nw, input int mode, input int rdy,
                       input int stall, input int full, input int abort_after, input int gapless);
        int t, full_left;
        bit abort_sent;
        g_mode = mode; g_base = {addr[29:2], 2'b00}; g_rdy_mode = rdy; g_stall = stall;
        build_expect(nw);
        clear_run_stats();
        @(posedge ddr_usrclk); #1;
        start = 1'b1; start_addr = addr; num_words = CNT_W'(nw); cmd_full = (full > 0);
        @(posedge ddr_usrclk); #1;
        start = 1'b0;
        check_eq("err_cleared", err, 0);
        check_eq("busy_after_start", busy, nw > 0);
        full_left = full - 1;
        t = 0;
        abort_sent = 0;
        while (n_done == 0 && t < 20000) begin
            if (full_left > 0) begin
                full_left--;
            end else begin
                if (full > 0 && cmd_full) check_eq("pop_while_full", n_pop, 0);
                cmd_full = (stall != 0) ? ($urandom_range(0, 4) == 0) : 1'b0;
            end
            if (abort_after >= 0 && !abort_sent && n_acc >= abort_after) begin
                abort = 1'b1;
                abort_sent = 1;
            end else begin
                abort = 1'b0;
            end
            @(posedge ddr_usrclk); #1;
            t++;
        end
        abort = 1'b0;
        cmd_full = 1'b0;
        check_eq("done_timeout", t < 20000, 1);
        repeat (3) @(posedge ddr_usrclk);
        #1;
        check_eq("done_count", n_done, 1);
        check_eq("busy_end", busy, 0);
        check_eq("rdq_drained", rdq.size(), 0);
        if (abort_after >= 0) begin
            check_eq("abort_cmds", n_cmd, 1);
            check_eq("abort_pops", n_pop, (nw < 64) ? nw : 64);
        end else begin
            check_eq("cmds", n_cmd, n_cmd_exp);
            check_eq("samples", n_acc, 3 * nw);
            check_eq("pops", n_pop, nw);
            if (nw > 0) check_eq("done_after_last", done_cyc > last_acc_cyc, 1);
            else        check_eq("zero_done_lat", done_cyc - start_cyc, 1);
        end
        if (full > 0 && stall == 0) check_eq("cmd_delay", first_cmd_cyc - start_cyc, full);
        if (gapless != 0) check_eq("no_gaps", last_acc_cyc - first_acc_cyc, 3 * nw - 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge ddr_usrclk);
        @(negedge ddr_usrclk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_cmd_en", cmd_en, 0);
        check_eq("rst_cmd_bl", cmd_bl, 0);
        check_eq("rst_cmd_addr", cmd_byte_addr, 0);
        check_eq("rst_cmd_instr", cmd_instr, 3'b001);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_valid", sample_valid, 0);
        check_eq("rst_sample", {sample_or, sample_trig, sample_data}, 0);
        @(posedge ddr_usrclk); #1;
        ddr_usrreset = 1'b0;

        run(30'h100, 64, 0, 0, 0, 0, -1, 1);
        run(30'h0, 130, 0, 0, 0, 0, -1, 0);
        run(30'h40, 1, 2, 2, 0, 0, -1, 0);
        run(30'h1000, 20, 1, 0, 0, 10, -1, 0);
        run(30'h2000, 128, 0, 0, 0, 0, 10, 0);
        run(30'h3000, 0, 0, 0, 0, 0, -1, 0);

        @(posedge ddr_usrclk); #1; rd_overflow = 1'b1;
        @(posedge ddr_usrclk); #1; rd_overflow = 1'b0;
        repeat (3) @(posedge ddr_usrclk);
        #1;
        check_eq("err_sticky", err, 1);

        for (int r = 0; r < 6; r++)
            run(30'($urandom), $urandom_range(1, 200), 1, 1, 1, 0, -1, 0);
        run(30'h3FFF_FF83, 100, 1, 1, 0, 0, -1, 0);

        // Reset in the middle of a transfer.
        g_mode = 1; g_base = 30'h500; g_rdy_mode = 0; g_stall = 0;
        build_expect(100);
        clear_run_stats();
        @(posedge ddr_usrclk); #1;
        start = 1'b1; start_addr = 30'h500; num_words = CNT_W'(100);
        @(posedge ddr_usrclk); #1;
        start = 1'b0;
        repeat (20) @(posedge ddr_usrclk);
        #1;
        ddr_usrreset = 1'b1;
        @(posedge ddr_usrclk); #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", sample_valid, 0);
        check_eq("midrst_rd_en", rd_en, 0);
        ddr_usrreset = 1'b0;
        rdq.delete();
        run(30'h800, 5, 0, 0, 0, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
